chan_mac_accum: RTL



---
 rtl/chan_mac_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/chan_mac_accum.sv
// Multi-channel signed multiply-accumulate; emits the frame sum per channel on its last beat. Optional saturation: CHAN_MAC_SAT_EN.
// Latency: last beat accepted at edge N -> out_valid after edge N+2; one beat per cycle.
// Backpressure: a held, unaccepted result freezes S1/S2 and drops in_ready; acc_clr also drops in_ready.
module chan_mac_accum #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 25,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0] in_coef,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_ovf
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic                     rdy_q;
    logic                     stall;
    logic                     accept;

    logic                     s1_vld, s1_last;
    logic signed [PROD_W-1:0] s1_prod;
    logic [CH_W-1:0]          s1_ch;
    logic                     s2_vld, s2_last;
    logic signed [PROD_W-1:0] s2_prod;
    logic [CH_W-1:0]          s2_ch;

    logic signed [ACC_W-1:0]  acc [NUM_CH];
    logic [NUM_CH-1:0]        ovf;

    logic                     ch_ok;
    logic                     s2_fire;
    logic signed [ACC_W-1:0]  acc_rd;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum_raw;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf_beat;
    logic                     ovf_rd;

    // rdy_q keeps in_ready low until the first edge after reset release
    assign stall    = out_valid & ~out_ready;
    assign in_ready = rdy_q & ~stall & ~acc_clr;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_prod <= '0;
            s1_ch   <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_prod <= '0;
            s2_ch   <= '0;
        end else if (acc_clr) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (!stall) begin
            s1_vld <= accept;
            if (accept) begin
                s1_prod <= $signed(in_data) * $signed(in_coef);
                s1_ch   <= in_ch;
                s1_last <= in_last;
            end
            s2_vld  <= s1_vld;
            s2_prod <= s1_prod;
            s2_ch   <= s1_ch;
            s2_last <= s1_last;
        end
    end

    // Beats to a channel beyond NUM_CH flow through and are dropped here
    always_comb begin
        ch_ok    = (int'(s2_ch) < NUM_CH);
        acc_rd   = ch_ok ? acc[s2_ch] : '0;
        ovf_rd   = ch_ok ? ovf[s2_ch] : 1'b0;
        prod_ext = s2_prod;
        sum_raw  = acc_rd + prod_ext;
        ovf_beat = (acc_rd[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc_rd[ACC_W-1]);
`ifdef CHAN_MAC_SAT_EN
        if (ovf_beat) begin
            sum = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = sum_raw;
        end
`else
        sum = sum_raw;
`endif
        s2_fire  = s2_vld & ch_ok & ~stall & ~acc_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            ovf <= '0;
        end else if (acc_clr) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            ovf <= '0;
        end else if (s2_fire) begin
            if (s2_last) begin
                acc[s2_ch] <= '0;
                ovf[s2_ch] <= 1'b0;
            end else begin
                acc[s2_ch] <= sum;
                ovf[s2_ch] <= ovf_rd | ovf_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_fire && s2_last) begin
            out_valid <= 1'b1;
            out_data  <= sum;
            out_ch    <= s2_ch;
            out_ovf   <= ovf_rd | ovf_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
